decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised RV32I/RV32E instruction-decode pipeline stage between fetch and execute.
- Decodes R, I, S, B, U, J and load/store formats.
- Generates sign-extended immediates and drives register-file read addresses.
- Registers all decoded fields behind a valid/ready handshake, with load-use stall and flush support.

Parameters:
- XLEN, 32, datapath and immediate width.
- NREGS, 32, architectural register count (16 = RV32E; register index >= NREGS is illegal).
- ALU_OP_W, 4, width of alu_opcode.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
- if_valid  input  1  fetch presents an instruction
- if_ready  output  1  stage accepts the instruction this cycle
- if_inst  input  32  instruction word
- if_pc  input  XLEN  PC of if_inst
- rf_raddr1, rf_raddr2  output  5  combinational read addresses = if_inst rs1/rs2 fields
- rf_rdata1, rf_rdata2  input  XLEN  register-file read data, same cycle
- ex_is_load  input  1  instruction in EX is a load
- ex_rd  input  5  destination register of the instruction in EX
- flush  input  1  kill the held instruction and any instruction accepted this cycle
- id_valid  output  1  decoded bundle valid
- id_ready  input  1  execute consumes the bundle
- id_pc  output  XLEN  registered PC
- src1, src2  output  XLEN  registered operands
- imm  output  XLEN  sign-extended immediate
- dreg  output  5  destination register (0 when no writeback)
- reg_we  output  1  instruction writes dreg
- alu_opcode  output  ALU_OP_W  ALU operation
- use_imm  output  1  ALU operand B is imm
- mem_rd, mem_wr  output  1  load / store
- branch, jump  output  1  B-type / JAL-JALR
- decoded_type  output  3  format code (debug)
- illegal  output  1  unsupported encoding

Behaviour:
- Reset (rst=0 at a clk edge): id_valid=0, all bundle outputs 0, decoded_type=TYPE_NONE, illegal=0.
- Latency: one cycle. An instruction accepted at edge N is presented with id_valid=1 after edge N.
- Stall condition: stall = if_valid && ex_is_load && ex_rd!=0 && ((rs1 used && rs1==ex_rd) || (rs2 used && rs2==ex_rd)).
  - rs1 is used by R, I, S, B and JALR; rs2 is used by R, S and B.
- if_ready = (!id_valid || id_ready) && !stall. It is combinational and must not depend on if_ready itself.
- Accept = if_valid && if_ready: load all bundle registers and set id_valid=1.
- Consume without new accept (id_valid && id_ready && !accept): clear id_valid; bundle contents are don't-care.
- Hold (id_valid && !id_ready): all outputs stable; if_ready=0.
- Flush has priority over accept and hold: next id_valid=0 regardless of if_valid and id_ready.
- Reset has priority over flush.
- Immediates, all sign-extended from the instruction MSB to XLEN:
  - I-type: inst[31:20].
  - S-type: {inst[31:25],inst[11:7]}.
  - B-type: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U-type: {inst[31:12],12'b0}.
  - J-type: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
- alu_opcode decodes from funct3 and funct7[5]. For I-type shifts, funct7[5] selects SRA vs SRL. SUB is produced only for R-type.
- Loads, stores, JALR and AUIPC use ALU_ADD. LUI uses ALU_PASSB.
- reg_we=0 for S and B types; dreg is forced to 0 whenever reg_we=0, and when rd=x0.
- illegal=1 when:
  - the opcode is not recognised, or
  - funct7 is invalid for the given funct3, or
  - any used register index >= NREGS.
  - An illegal instruction still issues (id_valid=1) with reg_we, mem_rd, mem_wr, branch and jump all forced to 0.
- src1/src2 capture rf_rdata1/2 at accept. Forwarding is done in EX, not here.

Decomposition:
- Shared package/header (extends define.h):
  - opcode constants;
  - funct3/funct7 constants;
  - ALU_* codes: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, PASSB;
  - TYPE_* codes: NONE, R, I, S, B, U, J.
- One sub-module, imm_gen: purely combinational, instruction word plus format in, XLEN immediate out.

Test Plan:
- Reset: rst=0 for 2 cycles with if_valid=1 -> id_valid=0, decoded_type=TYPE_NONE; accepts resume the first cycle after rst=1.
- add x3,x1,x2 (0x002081B3), rf_rdata1=5, rf_rdata2=7 -> next cycle: decoded_type=R, dreg=3, reg_we=1, alu_opcode=ALU_ADD, src1=5, src2=7, rf_raddr1=1, rf_raddr2=2.
- addi x5,x0,-1 (0xFFF00293) -> imm=0xFFFFFFFF, use_imm=1, dreg=5. sw x2,8(x1) (0x0020A423) -> imm=8, mem_wr=1, reg_we=0, dreg=0.
- Load-use: ex_is_load=1, ex_rd=1, if_inst=0x002081B3 -> if_ready=0, id_valid stays 0. With ex_rd=0 -> accepted.
- Back-pressure: id_valid=1, id_ready=0 for 3 cycles -> outputs stable, if_ready=0. Assert flush in cycle 2 -> id_valid=0 next cycle.
- if_inst=0x00000000 -> illegal=1, reg_we=0. With NREGS=16, add x17,x1,x2 -> illegal=1.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared encodings for the decode stage: opcodes, funct fields, ALU and
// format codes, the registered control bundle and small decode helpers.
package decode_stage_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        TYPE_NONE = 3'd0,
        TYPE_R    = 3'd1,
        TYPE_I    = 3'd2,
        TYPE_S    = 3'd3,
        TYPE_B    = 3'd4,
        TYPE_U    = 3'd5,
        TYPE_J    = 3'd6
    } type_e;

    typedef struct packed {
        type_e   dtype;
        alu_op_e alu;
        logic    reg_we;
        logic    use_imm;
        logic    mem_rd;
        logic    mem_wr;
        logic    branch;
        logic    jump;
        logic    illegal;
    } ctrl_t;

    // Register/immediate arithmetic; SUB only exists for register-register ops.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt, input logic is_reg);
        case (f3)
            F3_ADD:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    // Branch compare op: equality via XOR, ordering via SLT/SLTU.
    function automatic alu_op_e br_decode(input logic [2:0] f3);
        case (f3)
            F3_BEQ, F3_BNE:   return ALU_XOR;
            F3_BLT, F3_BGE:   return ALU_SLT;
            F3_BLTU, F3_BGEU: return ALU_SLTU;
            default:          return ALU_ADD;
        endcase
    endfunction

    // Only SUB/SRA (and SRAI) may set funct7 bit 5; all other funct7 bits must be zero.
    function automatic logic f7_ok(input logic [2:0] f3, input logic [6:0] f7, input logic is_reg);
        if (is_reg)
            return (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
        if (f3 == F3_SLL)
            return f7 == F7_BASE;
        if (f3 == F3_SR)
            return (f7 == F7_BASE) || (f7 == F7_ALT);
        return 1'b1;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch / register-file / execute signals seen by the decode stage.
interface decode_stage_if #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
);
    logic                if_valid;
    logic                if_ready;
    logic [31:0]         if_inst;
    logic [XLEN-1:0]     if_pc;
    logic [4:0]          rf_raddr1;
    logic [4:0]          rf_raddr2;
    logic [XLEN-1:0]     rf_rdata1;
    logic [XLEN-1:0]     rf_rdata2;
    logic                ex_is_load;
    logic [4:0]          ex_rd;
    logic                flush;
    logic                id_valid;
    logic                id_ready;
    logic [XLEN-1:0]     id_pc;
    logic [XLEN-1:0]     src1;
    logic [XLEN-1:0]     src2;
    logic [XLEN-1:0]     imm;
    logic [4:0]          dreg;
    logic                reg_we;
    logic [ALU_OP_W-1:0] alu_opcode;
    logic                use_imm;
    logic                mem_rd;
    logic                mem_wr;
    logic                branch;
    logic                jump;
    logic [2:0]          decoded_type;
    logic                illegal;

    // Environment side: fetch, register file and execute.
    modport master (
        output if_valid, if_inst, if_pc, rf_rdata1, rf_rdata2, ex_is_load, ex_rd, flush, id_ready,
        input  if_ready, rf_raddr1, rf_raddr2, id_valid, id_pc, src1, src2, imm, dreg, reg_we,
               alu_opcode, use_imm, mem_rd, mem_wr, branch, jump, decoded_type, illegal
    );

    // Decode stage side.
    modport slave (
        input  if_valid, if_inst, if_pc, rf_rdata1, rf_rdata2, ex_is_load, ex_rd, flush, id_ready,
        output if_ready, rf_raddr1, rf_raddr2, id_valid, id_pc, src1, src2, imm, dreg, reg_we,
               alu_opcode, use_imm, mem_rd, mem_wr, branch, jump, decoded_type, illegal
    );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: builds the sign-extended immediate for a decoded format.
module imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     i_inst,
    input  type_e           i_type,
    output logic [XLEN-1:0] o_imm
);
    logic [31:0] w_imm32;

    // Reassemble the immediate bits for each format, sign bit is always inst[31].
    always_comb begin
        w_imm32 = '0;
        case (i_type)
            TYPE_I:  w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            TYPE_S:  w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            TYPE_B:  w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            TYPE_U:  w_imm32 = {i_inst[31:12], 12'b0};
            TYPE_J:  w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));
endmodule

// File: rtl/decode_stage.sv
// RV32I/RV32E decode stage: combinational decode of the fetched word, load-use
// stall detection, and a single registered bundle behind a valid/ready handshake.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic clk,
    input  logic rst,
    decode_stage_if.slave bus
);
    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic            w_rs1_used, w_rs2_used;
    ctrl_t           w_ctl;
    logic [4:0]      w_dreg;
    logic [XLEN-1:0] w_imm;
    logic            w_stall, w_ready, w_accept;

    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_src1, r_src2, r_imm;
    logic [4:0]      r_dreg;
    ctrl_t           r_ctl;

    assign w_opc = bus.if_inst[6:0];
    assign w_rd  = bus.if_inst[11:7];
    assign w_f3  = bus.if_inst[14:12];
    assign w_rs1 = bus.if_inst[19:15];
    assign w_rs2 = bus.if_inst[24:20];
    assign w_f7  = bus.if_inst[31:25];

    // Format/control decode; illegal encodings keep their format but lose all side effects.
    always_comb begin
        w_ctl       = '0;
        w_ctl.dtype = TYPE_NONE;
        w_ctl.alu   = ALU_ADD;
        w_rs1_used  = 1'b0;
        w_rs2_used  = 1'b0;
        case (w_opc)
            OP_REG: begin
                w_ctl.dtype   = TYPE_R;
                w_ctl.reg_we  = 1'b1;
                w_rs1_used    = 1'b1;
                w_rs2_used    = 1'b1;
                w_ctl.alu     = alu_decode(w_f3, w_f7[5], 1'b1);
                w_ctl.illegal = !f7_ok(w_f3, w_f7, 1'b1);
            end
            OP_IMM: begin
                w_ctl.dtype   = TYPE_I;
                w_ctl.reg_we  = 1'b1;
                w_ctl.use_imm = 1'b1;
                w_rs1_used    = 1'b1;
                w_ctl.alu     = alu_decode(w_f3, w_f7[5], 1'b0);
                w_ctl.illegal = !f7_ok(w_f3, w_f7, 1'b0);
            end
            OP_LOAD: begin
                w_ctl.dtype   = TYPE_I;
                w_ctl.reg_we  = 1'b1;
                w_ctl.use_imm = 1'b1;
                w_ctl.mem_rd  = 1'b1;
                w_rs1_used    = 1'b1;
            end
            OP_JALR: begin
                w_ctl.dtype   = TYPE_I;
                w_ctl.reg_we  = 1'b1;
                w_ctl.use_imm = 1'b1;
                w_ctl.jump    = 1'b1;
                w_rs1_used    = 1'b1;
            end
            OP_STORE: begin
                w_ctl.dtype   = TYPE_S;
                w_ctl.use_imm = 1'b1;
                w_ctl.mem_wr  = 1'b1;
                w_rs1_used    = 1'b1;
                w_rs2_used    = 1'b1;
            end
            OP_BRANCH: begin
                w_ctl.dtype  = TYPE_B;
                w_ctl.branch = 1'b1;
                w_ctl.alu    = br_decode(w_f3);
                w_rs1_used   = 1'b1;
                w_rs2_used   = 1'b1;
            end
            OP_LUI: begin
                w_ctl.dtype   = TYPE_U;
                w_ctl.reg_we  = 1'b1;
                w_ctl.use_imm = 1'b1;
                w_ctl.alu     = ALU_PASSB;
            end
            OP_AUIPC: begin
                w_ctl.dtype   = TYPE_U;
                w_ctl.reg_we  = 1'b1;
                w_ctl.use_imm = 1'b1;
            end
            OP_JAL: begin
                w_ctl.dtype   = TYPE_J;
                w_ctl.reg_we  = 1'b1;
                w_ctl.use_imm = 1'b1;
                w_ctl.jump    = 1'b1;
            end
            default: w_ctl.illegal = 1'b1;
        endcase
        // RV32E: any register the instruction actually touches must exist.
        if ((w_rs1_used && (int'(w_rs1) >= NREGS)) ||
            (w_rs2_used && (int'(w_rs2) >= NREGS)) ||
            (w_ctl.reg_we && (int'(w_rd) >= NREGS)))
            w_ctl.illegal = 1'b1;
        if (w_ctl.illegal) begin
            w_ctl.reg_we = 1'b0;
            w_ctl.mem_rd = 1'b0;
            w_ctl.mem_wr = 1'b0;
            w_ctl.branch = 1'b0;
            w_ctl.jump   = 1'b0;
        end
    end

    assign w_dreg = w_ctl.reg_we ? w_rd : 5'd0;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_inst (bus.if_inst[31:7]),
        .i_type (w_ctl.dtype),
        .o_imm  (w_imm)
    );

    // A load in EX cannot forward in time to a dependent instruction here.
    assign w_stall  = bus.if_valid && bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                      ((w_rs1_used && (w_rs1 == bus.ex_rd)) || (w_rs2_used && (w_rs2 == bus.ex_rd)));
    assign w_ready  = (!r_valid || bus.id_ready) && !w_stall;
    assign w_accept = bus.if_valid && w_ready;

    // Bundle register: flush beats accept/hold, reset beats everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_src1  <= '0;
            r_src2  <= '0;
            r_imm   <= '0;
            r_dreg  <= '0;
            r_ctl   <= '0;
        end else begin
            if (bus.flush)
                r_valid <= 1'b0;
            else if (w_accept)
                r_valid <= 1'b1;
            else if (bus.id_ready)
                r_valid <= 1'b0;
            if (w_accept) begin
                r_pc   <= bus.if_pc;
                r_src1 <= bus.rf_rdata1;
                r_src2 <= bus.rf_rdata2;
                r_imm  <= w_imm;
                r_dreg <= w_dreg;
                r_ctl  <= w_ctl;
            end
        end
    end

    assign bus.if_ready     = w_ready;
    assign bus.rf_raddr1    = w_rs1;
    assign bus.rf_raddr2    = w_rs2;
    assign bus.id_valid     = r_valid;
    assign bus.id_pc        = r_pc;
    assign bus.src1         = r_src1;
    assign bus.src2         = r_src2;
    assign bus.imm          = r_imm;
    assign bus.dreg         = r_dreg;
    assign bus.reg_we       = r_ctl.reg_we;
    assign bus.alu_opcode   = ALU_OP_W'(r_ctl.alu);
    assign bus.use_imm      = r_ctl.use_imm;
    assign bus.mem_rd       = r_ctl.mem_rd;
    assign bus.mem_wr       = r_ctl.mem_wr;
    assign bus.branch       = r_ctl.branch;
    assign bus.jump         = r_ctl.jump;
    assign bus.decoded_type = r_ctl.dtype;
    assign bus.illegal      = r_ctl.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table plus reset, back-pressure,
// flush and RV32E register-range sequences.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic clk;
    logic rst;

    decode_stage_if #(.XLEN(32), .ALU_OP_W(4)) b();
    decode_stage_if #(.XLEN(32), .ALU_OP_W(4)) b16();

    decode_stage #(.XLEN(32), .NREGS(32), .ALU_OP_W(4)) dut (.clk(clk), .rst(rst), .bus(b));
    decode_stage #(.XLEN(32), .NREGS(16), .ALU_OP_W(4)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    assign b16.if_valid   = b.if_valid;
    assign b16.if_inst    = b.if_inst;
    assign b16.if_pc      = b.if_pc;
    assign b16.rf_rdata1  = b.rf_rdata1;
    assign b16.rf_rdata2  = b.rf_rdata2;
    assign b16.ex_is_load = b.ex_is_load;
    assign b16.ex_rd      = b.ex_rd;
    assign b16.flush      = b.flush;
    assign b16.id_ready   = b.id_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] d1, d2;
        logic        ld;
        logic [4:0]  exrd;
        logic        rdy;
        logic [2:0]  ty;
        logic [4:0]  dreg;
        logic        we;
        logic [3:0]  alu;
        logic        ui, mr, mw, br, jp, il;
        logic [31:0] imm;
    } vec_t;

    int n_chk = 0;
    int n_bad = 0;

    function automatic vec_t mk(logic [31:0] inst, d1, d2, logic ld, logic [4:0] exrd, logic rdy,
                                logic [2:0] ty, logic [4:0] dreg, logic we, logic [3:0] alu,
                                logic ui, mr, mw, br, jp, il, logic [31:0] imm);
        vec_t v;
        v.inst = inst; v.d1 = d1; v.d2 = d2; v.ld = ld; v.exrd = exrd; v.rdy = rdy;
        v.ty = ty; v.dreg = dreg; v.we = we; v.alu = alu; v.ui = ui; v.mr = mr;
        v.mw = mw; v.br = br; v.jp = jp; v.il = il; v.imm = imm;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%08h want 0x%08h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, pc, d1, d2,
                         input logic ld, input logic [4:0] exrd, input logic rdy, input logic fl);
        b.if_valid = v; b.if_inst = inst; b.if_pc = pc; b.rf_rdata1 = d1; b.rf_rdata2 = d2;
        b.ex_is_load = ld; b.ex_rd = exrd; b.id_ready = rdy; b.flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[20];
    vec_t        v;
    logic [31:0] pc;
    logic [31:0] rv_inst[3];
    logic        rv_ill16[3];
    logic [4:0]  rv_dreg16[3];

    initial begin
        vecs[0]  = mk(32'h002081B3,  5,  7, 0, 0, 1, TYPE_R,  3, 1, ALU_ADD,   0, 0, 0, 0, 0, 0, 32'h0);
        vecs[1]  = mk(32'hFFF00293, 11, 22, 0, 0, 1, TYPE_I,  5, 1, ALU_ADD,   1, 0, 0, 0, 0, 0, 32'hFFFFFFFF);
        vecs[2]  = mk(32'h0020A423, 33, 44, 0, 0, 1, TYPE_S,  0, 0, ALU_ADD,   1, 0, 1, 0, 0, 0, 32'h8);
        vecs[3]  = mk(32'hFFC12203,  1,  2, 0, 0, 1, TYPE_I,  4, 1, ALU_ADD,   1, 1, 0, 0, 0, 0, 32'hFFFFFFFC);
        vecs[4]  = mk(32'h40838333,  3,  4, 0, 0, 1, TYPE_R,  6, 1, ALU_SUB,   0, 0, 0, 0, 0, 0, 32'h0);
        vecs[5]  = mk(32'h40355493,  6,  8, 0, 0, 1, TYPE_I,  9, 1, ALU_SRA,   1, 0, 0, 0, 0, 0, 32'h403);
        vecs[6]  = mk(32'hFE208CE3,  9, 10, 0, 0, 1, TYPE_B,  0, 0, ALU_XOR,   0, 0, 0, 1, 0, 0, 32'hFFFFFFF8);
        vecs[7]  = mk(32'h12345537, 12, 13, 0, 0, 1, TYPE_U, 10, 1, ALU_PASSB, 1, 0, 0, 0, 0, 0, 32'h12345000);
        vecs[8]  = mk(32'hFFFFF117, 14, 15, 0, 0, 1, TYPE_U,  2, 1, ALU_ADD,   1, 0, 0, 0, 0, 0, 32'hFFFFF000);
        vecs[9]  = mk(32'h001000EF, 16, 17, 0, 0, 1, TYPE_J,  1, 1, ALU_ADD,   1, 0, 0, 0, 1, 0, 32'h800);
        vecs[10] = mk(32'h00008067, 18, 19, 0, 0, 1, TYPE_I,  0, 1, ALU_ADD,   1, 0, 0, 0, 1, 0, 32'h0);
        vecs[11] = mk(32'h00000000, 20, 21, 0, 0, 1, TYPE_NONE, 0, 0, ALU_ADD, 0, 0, 0, 0, 0, 1, 32'h0);
        vecs[12] = mk(32'h022081B3, 22, 23, 0, 0, 1, TYPE_R,  0, 0, ALU_ADD,   0, 0, 0, 0, 0, 1, 32'h0);
        vecs[13] = mk(32'h002081B3,  5,  7, 1, 1, 0, TYPE_R,  3, 1, ALU_ADD,   0, 0, 0, 0, 0, 0, 32'h0);
        vecs[14] = mk(32'h002081B3,  5,  7, 1, 2, 0, TYPE_R,  3, 1, ALU_ADD,   0, 0, 0, 0, 0, 0, 32'h0);
        vecs[15] = mk(32'h002081B3, 24, 25, 1, 0, 1, TYPE_R,  3, 1, ALU_ADD,   0, 0, 0, 0, 0, 0, 32'h0);
        vecs[16] = mk(32'h12345537, 26, 27, 1, 8, 1, TYPE_U, 10, 1, ALU_PASSB, 1, 0, 0, 0, 0, 0, 32'h12345000);
        vecs[17] = mk(32'h002081B3, 28, 29, 0, 1, 1, TYPE_R,  3, 1, ALU_ADD,   0, 0, 0, 0, 0, 0, 32'h0);
        vecs[18] = mk(32'h0020A423, 30, 31, 1, 2, 0, TYPE_S,  0, 0, ALU_ADD,   1, 0, 1, 0, 0, 0, 32'h8);
        vecs[19] = mk(32'h40109093, 32, 33, 0, 0, 1, TYPE_I,  0, 0, ALU_SLL,   1, 0, 0, 0, 0, 1, 32'h401);

        // Reset held for two edges while fetch offers addi.
        rst = 1'b0;
        drive(1, 32'hFFF00293, 32'h100, 32'h55, 32'h66, 0, 0, 1, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_id_valid", c, b.id_valid, 0);
            chk("rst_type", c, b.decoded_type, TYPE_NONE);
            chk("rst_illegal", c, b.illegal, 0);
            chk("rst_imm", c, b.imm, 0);
            chk("rst_reg_we", c, b.reg_we, 0);
            chk("rst_src1", c, b.src1, 0);
        end
        rst = 1'b1;
        tick();
        chk("post_rst_valid", 0, b.id_valid, 1);
        chk("post_rst_imm", 0, b.imm, 32'hFFFFFFFF);
        chk("post_rst_src1", 0, b.src1, 32'h55);
        chk("post_rst_pc", 0, b.id_pc, 32'h100);

        // Vector table, execute always ready.
        for (int i = 0; i < 20; i++) begin
            v  = vecs[i];
            pc = 32'h1000 + 32'(i) * 4;
            drive(1, v.inst, pc, v.d1, v.d2, v.ld, v.exrd, 1, 0);
            #1;
            chk("if_ready", i, b.if_ready, v.rdy);
            chk("rf_raddr1", i, b.rf_raddr1, v.inst[19:15]);
            chk("rf_raddr2", i, b.rf_raddr2, v.inst[24:20]);
            tick();
            chk("id_valid", i, b.id_valid, v.rdy);
            if (v.rdy) begin
                chk("id_pc", i, b.id_pc, pc);
                chk("src1", i, b.src1, v.d1);
                chk("src2", i, b.src2, v.d2);
                chk("imm", i, b.imm, v.imm);
                chk("dreg", i, b.dreg, v.dreg);
                chk("reg_we", i, b.reg_we, v.we);
                chk("alu_opcode", i, b.alu_opcode, v.alu);
                chk("use_imm", i, b.use_imm, v.ui);
                chk("mem_rd", i, b.mem_rd, v.mr);
                chk("mem_wr", i, b.mem_wr, v.mw);
                chk("branch", i, b.branch, v.br);
                chk("jump", i, b.jump, v.jp);
                chk("decoded_type", i, b.decoded_type, v.ty);
                chk("illegal", i, b.illegal, v.il);
            end
        end

        // Back-pressure: hold add x3 while fetch offers addi, then flush.
        drive(0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0);
        tick();
        chk("bp_drain", 0, b.id_valid, 0);
        drive(1, 32'h002081B3, 32'h2000, 5, 7, 0, 0, 0, 0);
        tick();
        chk("bp_load_valid", 0, b.id_valid, 1);
        drive(1, 32'hFFF00293, 32'h2004, 99, 98, 0, 0, 0, 0);
        #1;
        chk("bp_if_ready", 1, b.if_ready, 0);
        tick();
        chk("bp_valid", 1, b.id_valid, 1);
        chk("bp_dreg", 1, b.dreg, 3);
        chk("bp_src1", 1, b.src1, 5);
        chk("bp_type", 1, b.decoded_type, TYPE_R);
        chk("bp_pc", 1, b.id_pc, 32'h2000);
        b.flush = 1'b1;
        #1;
        chk("bp_if_ready", 2, b.if_ready, 0);
        tick();
        chk("bp_flush_valid", 2, b.id_valid, 0);
        b.flush = 1'b0;
        #1;
        chk("bp_if_ready", 3, b.if_ready, 1);
        tick();
        chk("bp_reload_valid", 3, b.id_valid, 1);
        chk("bp_reload_dreg", 3, b.dreg, 5);
        chk("bp_reload_src1", 3, b.src1, 99);

        // Flush kills an instruction accepted in the same cycle.
        drive(1, 32'h002081B3, 32'h3000, 1, 2, 0, 0, 1, 1);
        #1;
        chk("fl_if_ready", 0, b.if_ready, 1);
        tick();
        chk("fl_valid", 0, b.id_valid, 0);

        // RV32E register range: x17 dest, x16 source illegal; x15 legal.
        rv_inst[0] = 32'h002088B3; rv_ill16[0] = 1; rv_dreg16[0] = 0;
        rv_inst[1] = 32'h010081B3; rv_ill16[1] = 1; rv_dreg16[1] = 0;
        rv_inst[2] = 32'h002087B3; rv_ill16[2] = 0; rv_dreg16[2] = 15;
        for (int k = 0; k < 3; k++) begin
            drive(1, rv_inst[k], 32'h4000, 1, 2, 0, 0, 1, 0);
            tick();
            chk("e_valid", k, b16.id_valid, 1);
            chk("e_illegal", k, b16.illegal, rv_ill16[k]);
            chk("e_reg_we", k, b16.reg_we, !rv_ill16[k]);
            chk("e_dreg", k, b16.dreg, rv_dreg16[k]);
            chk("i_illegal", k, b.illegal, 0);
        end
        chk("i_dreg_x17", 0, 32'(b.dreg) + 32'd2, 32'd17);

        drive(0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
